even_parity_frame_checker: RTL and testbench

Serial receiver and checker for even-parity frames: the receive-side counterpart of the 4-bit even parity generator. It takes a bit stream of DATA_W data bits followed by one even-parity bit, rebuilds the parallel word and flags parity errors. It sits between a serial link deserialiser and parallel consumer logic. An optional saturating error counter can be compiled in.

---
 rtl/even_parity_frame_checker_if.sv | 27 ++
 rtl/even_parity_frame_checker.sv | 112 +++++++++++
 tb/tb_even_parity_frame_checker.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/even_parity_frame_checker_if.sv
// Serial receive bus for even_parity_frame_checker: qualified bit stream in,
// completed word, status and debug state out.
interface even_parity_frame_checker_if #(
  parameter int DATA_W = 4
);
  // Handshake: rx_bit/rx_sof are meaningful only in cycles with rx_valid=1.
  // There is no ready; the checker accepts every qualified bit.
  logic              rx_bit;
  logic              rx_valid;
  logic              rx_sof;
  logic [DATA_W-1:0] data_out;
  logic              frame_done;
  logic              parity_err;
  logic              busy;
  logic [7:0]        err_count;
  logic [1:0]        state_dbg;

  modport master (
    output rx_bit, rx_valid, rx_sof,
    input  data_out, frame_done, parity_err, busy, err_count, state_dbg
  );

  modport slave (
    input  rx_bit, rx_valid, rx_sof,
    output data_out, frame_done, parity_err, busy, err_count, state_dbg
  );
endinterface

// File: rtl/even_parity_frame_checker.sv
// Even-parity serial frame receiver: DATA_W data bits (LSB first) then a parity bit.
// Optional saturating parity-error counter enabled by macro PARITY_ERR_CNT_EN.
module even_parity_frame_checker #(
  parameter int DATA_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  even_parity_frame_checker_if.slave  bus
);
  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic              acc_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_q;
  logic              done_q;
  logic              err_q;

  logic start;
  logic last_bit;
  logic accept;
  logic frame_err;

  // An sof bit always starts a new frame, even when it aborts one in progress.
  assign start     = bus.rx_valid & bus.rx_sof;
  assign last_bit  = (cnt_q == CW'(DATA_W - 1));
  assign accept    = (state_q == PARITY) & bus.rx_valid & ~bus.rx_sof;
  assign frame_err = acc_q ^ bus.rx_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = DATA;
      end
      DATA: begin
        if (start)                            state_d = DATA;
        else if (bus.rx_valid && last_bit)    state_d = PARITY;
      end
      PARITY: begin
        if (start)             state_d = DATA;
        else if (bus.rx_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= accept;
      if (start) begin
        shift_q[0] <= bus.rx_bit;
        acc_q      <= bus.rx_bit;
        cnt_q      <= CW'(1);
      end else if (bus.rx_valid && state_q == DATA) begin
        shift_q[cnt_q] <= bus.rx_bit;
        acc_q          <= acc_q ^ bus.rx_bit;
        cnt_q          <= cnt_q + CW'(1);
      end else if (accept) begin
        data_q <= shift_q;
        err_q  <= frame_err;
        cnt_q  <= '0;
        acc_q  <= 1'b0;
      end
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Counts alongside the frame_done edge so it is current when frame_done is seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else if (accept && frame_err && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = 8'd0;
`endif

  assign bus.data_out   = data_q;
  assign bus.frame_done = done_q;
  assign bus.parity_err = err_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_even_parity_frame_checker.sv
// Directed self-checking bench for even_parity_frame_checker (DATA_W=4);
// err_count expectations follow PARITY_ERR_CNT_EN.
module tb_even_parity_frame_checker;
  localparam int DATA_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   exp_cnt = 0;
  logic [DATA_W:0] exp_q[$];

  even_parity_frame_checker_if #(.DATA_W(DATA_W)) bus ();

  even_parity_frame_checker #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) done_cnt++;
  end

  // drivers
  task automatic step(input logic v, input logic s, input logic b);
    bus.rx_valid = v;
    bus.rx_sof   = s;
    bus.rx_bit   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p);
    step(1'b1, 1'b1, d[0]);
    for (int i = 1; i < DATA_W; i++) step(1'b1, 1'b0, d[i]);
    step(1'b1, 1'b0, p);
  endtask

  // model of the optional counter
  task automatic note_frame(input logic err);
`ifdef PARITY_ERR_CNT_EN
    if (err && exp_cnt < 255) exp_cnt++;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    total += 5;
    if (bus.data_out !== 4'b0000) begin bad++; $display("FAIL reset_data got=%b exp=0000", bus.data_out); end
    if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.frame_done); end
    if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", bus.parity_err); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    if (bus.err_count !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.err_count); end
  endtask

  task automatic test_good_frame();
    send_frame(4'b1011, 1'b1);
    note_frame(1'b0);
    total += 5;
    if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL good_done got=%b exp=1", bus.frame_done); end
    if (bus.data_out !== 4'b1011) begin bad++; $display("FAIL good_data got=%b exp=1011", bus.data_out); end
    if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL good_perr got=%b exp=0", bus.parity_err); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL good_busy got=%b exp=0", bus.busy); end
    if (bus.err_count !== 8'(exp_cnt)) begin bad++; $display("FAIL good_cnt got=%0d exp=%0d", bus.err_count, exp_cnt); end
    idle(1);
    total += 2;
    if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL good_pulse got=%b exp=0", bus.frame_done); end
    if (bus.data_out !== 4'b1011) begin bad++; $display("FAIL good_hold got=%b exp=1011", bus.data_out); end
  endtask

  task automatic test_bad_parity();
    send_frame(4'b0110, 1'b1);
    note_frame(1'b1);
    total += 4;
    if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL bad_done got=%b exp=1", bus.frame_done); end
    if (bus.data_out !== 4'b0110) begin bad++; $display("FAIL bad_data got=%b exp=0110", bus.data_out); end
    if (bus.parity_err !== 1'b1) begin bad++; $display("FAIL bad_perr got=%b exp=1", bus.parity_err); end
    if (bus.err_count !== 8'(exp_cnt)) begin bad++; $display("FAIL bad_cnt got=%0d exp=%0d", bus.err_count, exp_cnt); end
    idle(2);
    total += 1;
    if (bus.parity_err !== 1'b1) begin bad++; $display("FAIL bad_hold got=%b exp=1", bus.parity_err); end
  endtask

  task automatic test_gapped();
    int start_done;
    int busy_low;
    start_done = done_cnt;
    busy_low = 0;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < DATA_W; i++) begin
      for (int g = 0; g < 3; g++) begin
        step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        if (bus.busy !== 1'b1) busy_low++;
      end
      step(1'b1, 1'b0, 1'b0);
      if (i < DATA_W - 1 && bus.busy !== 1'b1) busy_low++;
    end
    note_frame(1'b0);
    idle(2);
    total += 4;
    if (busy_low != 0) begin bad++; $display("FAIL gap_busy low_cycles=%0d exp=0", busy_low); end
    if (done_cnt - start_done != 1) begin bad++; $display("FAIL gap_done pulses=%0d exp=1", done_cnt - start_done); end
    if (bus.data_out !== 4'b0000) begin bad++; $display("FAIL gap_data got=%b exp=0000", bus.data_out); end
    if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL gap_perr got=%b exp=0", bus.parity_err); end
  endtask

  task automatic test_resync();
    int start_done;
    start_done = done_cnt;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    send_frame(4'b1111, 1'b0);
    note_frame(1'b0);
    idle(1);
    total += 4;
    if (done_cnt - start_done != 1) begin bad++; $display("FAIL resync_done pulses=%0d exp=1", done_cnt - start_done); end
    if (bus.data_out !== 4'b1111) begin bad++; $display("FAIL resync_data got=%b exp=1111", bus.data_out); end
    if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL resync_perr got=%b exp=0", bus.parity_err); end
    if (bus.err_count !== 8'(exp_cnt)) begin bad++; $display("FAIL resync_cnt got=%0d exp=%0d", bus.err_count, exp_cnt); end
  endtask

  task automatic test_idle_ignore();
    int start_done;
    start_done = done_cnt;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    total += 2;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignore_busy got=%b exp=0", bus.busy); end
    if (done_cnt - start_done != 0) begin bad++; $display("FAIL ignore_done pulses=%0d exp=0", done_cnt - start_done); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W:0] exp;
    exp_q.push_back({1'b0, 4'b0001});
    exp_q.push_back({1'b1, 4'b0011});
    send_frame(4'b0001, 1'b1);
    note_frame(1'b0);
    exp = exp_q.pop_front();
    total += 2;
    if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL b2b_done0 got=%b exp=1", bus.frame_done); end
    if ({bus.parity_err, bus.data_out} !== exp) begin bad++; $display("FAIL b2b_word0 got=%b exp=%b", {bus.parity_err, bus.data_out}, exp); end
    send_frame(4'b0011, 1'b1);
    note_frame(1'b1);
    exp = exp_q.pop_front();
    total += 3;
    if (bus.frame_done !== 1'b1) begin bad++; $display("FAIL b2b_done1 got=%b exp=1", bus.frame_done); end
    if ({bus.parity_err, bus.data_out} !== exp) begin bad++; $display("FAIL b2b_word1 got=%b exp=%b", {bus.parity_err, bus.data_out}, exp); end
    if (bus.err_count !== 8'(exp_cnt)) begin bad++; $display("FAIL b2b_cnt got=%0d exp=%0d", bus.err_count, exp_cnt); end
    idle(1);
  endtask

  task automatic test_reset_mid_frame();
    int start_done;
    step(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < DATA_W; i++) step(1'b1, 1'b0, 1'b1);
    total += 1;
    if (bus.state_dbg !== 2'd2) begin bad++; $display("FAIL mid_state got=%0d exp=2", bus.state_dbg); end
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    exp_cnt = 0;
    start_done = done_cnt;
    total += 4;
    if (bus.data_out !== 4'b0000) begin bad++; $display("FAIL mid_data got=%b exp=0000", bus.data_out); end
    if (bus.parity_err !== 1'b0) begin bad++; $display("FAIL mid_perr got=%b exp=0", bus.parity_err); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
    if (bus.err_count !== 8'd0) begin bad++; $display("FAIL mid_cnt got=%0d exp=0", bus.err_count); end
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    total += 2;
    if (done_cnt - start_done != 0) begin bad++; $display("FAIL mid_orphan pulses=%0d exp=0", done_cnt - start_done); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_orphan_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      send_frame(4'b0001, 1'b0);
      note_frame(1'b1);
      total++;
      if (bus.err_count !== 8'(exp_cnt)) begin
        bad++;
        $display("FAIL sat_cnt frame=%0d got=%0d exp=%0d", i, bus.err_count, exp_cnt);
      end
    end
    total += 1;
`ifdef PARITY_ERR_CNT_EN
    if (bus.err_count !== 8'd255) begin bad++; $display("FAIL sat_final got=%0d exp=255", bus.err_count); end
`else
    if (bus.err_count !== 8'd0) begin bad++; $display("FAIL sat_final got=%0d exp=0", bus.err_count); end
`endif
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_sof   = 1'b0;
    bus.rx_bit   = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_gapped();
    test_resync();
    test_idle_ignore();
    test_back_to_back();
    test_reset_mid_frame();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
